// File: rtl/qr_pkg.sv
// Shared constants and types for the 8x4 Givens-rotation QR sequencer.
package qr_pkg;

  localparam int ROWS   = 8;
  localparam int COLS   = 4;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 2;
  localparam int ELEM_W = ROW_W + COL_W;

  localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(ROWS * COLS - 1);

  localparam logic CMD_VEC = 1'b1;
  localparam logic CMD_ROT = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/qr_cmd_gen.sv
// Walks the (j, i, k) loop nest that orders the vectoring and rotation commands.
module qr_cmd_gen
  import qr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic             cmd_vec,
  output logic [ROW_W-1:0] cmd_row_top,
  output logic [ROW_W-1:0] cmd_row_bot,
  output logic [COL_W-1:0] cmd_col,
  output logic             last
);

  logic [COL_W-1:0] col_j;
  logic [ROW_W-1:0] row_i;
  logic [COL_W-1:0] col_k;
  logic             is_vec;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col_j  <= '0;
      row_i  <= ROW_W'(ROWS - 1);
      col_k  <= '0;
      is_vec <= CMD_VEC;
    end else if (advance) begin
      if (is_vec && (col_j != COL_W'(COLS - 1))) begin
        is_vec <= CMD_ROT;
        col_k  <= col_j + COL_W'(1);
      end else if (!is_vec && (col_k != COL_W'(COLS - 1))) begin
        col_k <= col_k + COL_W'(1);
      end else begin
        // Row pair finished: step up one pair, or move to the next column.
        is_vec <= CMD_VEC;
        if (row_i > (ROW_W'(col_j) + ROW_W'(1))) begin
          row_i <= row_i - ROW_W'(1);
        end else begin
          col_j <= col_j + COL_W'(1);
          row_i <= ROW_W'(ROWS - 1);
        end
      end
    end
  end

  assign cmd_vec     = is_vec;
  assign cmd_row_top = row_i - ROW_W'(1);
  assign cmd_row_bot = row_i;
  assign cmd_col     = is_vec ? col_j : col_k;
  assign last        = is_vec && (col_j == COL_W'(COLS - 1)) && (row_i == ROW_W'(COLS));

endmodule

// File: rtl/qr_rot_sched.sv
// QR sequencer: loads A, issues Givens commands to the CORDIC PE, writes back R.
//   state    | meaning
//   IDLE     | waiting for en
//   LOAD     | reading A row-major into the register file
//   ISSUE    | presenting the 60 commands under the hazard rules
//   DRAIN    | waiting for outstanding commands to complete
//   WRITE    | writing R row-major to the R RAM
//   DONE     | valid held until en drops
module qr_rot_sched
  import qr_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rd_A,
  output logic [ROW_W-1:0] rd_A_row_addr,
  output logic [COL_W-1:0] rd_A_col_addr,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_vec,
  output logic [ROW_W-1:0] cmd_row_top,
  output logic [ROW_W-1:0] cmd_row_bot,
  output logic [COL_W-1:0] cmd_col,
  input  logic             cmd_done,
  output logic             wr_R,
  output logic [ROW_W-1:0] wr_R_row_addr,
  output logic [COL_W-1:0] wr_R_col_addr,
  output logic             valid
);

  localparam int OUT_W = 3;

  state_t            state, state_next;
  logic [ELEM_W-1:0] elem_cnt;
  logic [OUT_W-1:0]  out_cnt;

  logic              gen_vec, gen_last, gen_clear;
  logic [ROW_W-1:0]  gen_top, gen_bot;
  logic [COL_W-1:0]  gen_col;

  logic              hold_vec;
  logic [ROW_W-1:0]  hold_top, hold_bot;
  logic [COL_W-1:0]  hold_col;

  logic              issue_ok, handshake, done_credit, elem_last;

  assign gen_clear = (state == ST_IDLE);

  qr_cmd_gen u_cmd_gen (
    .clk         (clk),
    .rst         (rst),
    .clear       (gen_clear),
    .advance     (handshake),
    .cmd_vec     (gen_vec),
    .cmd_row_top (gen_top),
    .cmd_row_bot (gen_bot),
    .cmd_col     (gen_col),
    .last        (gen_last)
  );

  // A done pulse only frees a slot from the next cycle on.
  assign issue_ok    = gen_vec ? (out_cnt == '0) : (int'(out_cnt) < MAX_OUT);
  assign handshake   = cmd_valid && cmd_ready;
  assign done_credit = cmd_done && (out_cnt != '0);
  assign elem_last   = (elem_cnt == ELEM_LAST);

  always_comb begin
    state_next = state;
    rd_A       = 1'b0;
    wr_R       = 1'b0;
    valid      = 1'b0;
    cmd_valid  = 1'b0;
    unique case (state)
      ST_IDLE:  if (en) state_next = ST_LOAD;
      ST_LOAD: begin
        rd_A = 1'b1;
        if (elem_last) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        cmd_valid = issue_ok;
        if (issue_ok && cmd_ready && gen_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (out_cnt == '0) state_next = ST_WRITE;
      ST_WRITE: begin
        wr_R = 1'b1;
        if (elem_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        valid = 1'b1;
        if (!en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      elem_cnt <= '0;
      out_cnt  <= '0;
      hold_vec <= 1'b0;
      hold_top <= '0;
      hold_bot <= '0;
      hold_col <= '0;
    end else begin
      state <= state_next;
      if (state == ST_LOAD || state == ST_WRITE) elem_cnt <= elem_cnt + ELEM_W'(1);
      else elem_cnt <= '0;
      case ({handshake, done_credit})
        2'b10:   out_cnt <= out_cnt + OUT_W'(1);
        2'b01:   out_cnt <= out_cnt - OUT_W'(1);
        default: ;
      endcase
      if (cmd_valid) begin
        hold_vec <= gen_vec;
        hold_top <= gen_top;
        hold_bot <= gen_bot;
        hold_col <= gen_col;
      end
    end
  end

  // Fields keep showing the last presented command while nothing is offered.
  assign cmd_vec     = cmd_valid ? gen_vec : hold_vec;
  assign cmd_row_top = cmd_valid ? gen_top : hold_top;
  assign cmd_row_bot = cmd_valid ? gen_bot : hold_bot;
  assign cmd_col     = cmd_valid ? gen_col : hold_col;

  assign rd_A_row_addr = elem_cnt[ELEM_W-1:COL_W];
  assign rd_A_col_addr = elem_cnt[COL_W-1:0];
  assign wr_R_row_addr = elem_cnt[ELEM_W-1:COL_W];
  assign wr_R_col_addr = elem_cnt[COL_W-1:0];

endmodule

// File: tb/tb_qr_rot_sched.sv
// Bench for qr_rot_sched: phase-level reference model, scenario table and corner sequences.
module tb_qr_rot_sched;

  localparam int MAX_OUT = 2;
  localparam int NCMD    = 60;
  localparam int NELEM   = 32;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_ISSUE = 2, PH_DRAIN = 3, PH_WRITE = 4, PH_DONE = 5;

  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, cmd_ready = 1'b0, cmd_done = 1'b0;
  logic       rd_A, cmd_valid, cmd_vec, wr_R, valid;
  logic [2:0] rd_A_row_addr, cmd_row_top, cmd_row_bot, wr_R_row_addr;
  logic [1:0] rd_A_col_addr, cmd_col, wr_R_col_addr;

  qr_rot_sched #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .rd_A(rd_A), .rd_A_row_addr(rd_A_row_addr), .rd_A_col_addr(rd_A_col_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vec(cmd_vec),
    .cmd_row_top(cmd_row_top), .cmd_row_bot(cmd_row_bot), .cmd_col(cmd_col),
    .cmd_done(cmd_done),
    .wr_R(wr_R), .wr_R_row_addr(wr_R_row_addr), .wr_R_col_addr(wr_R_col_addr),
    .valid(valid)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int n; int v; int t; int b; int c; } ref_t;
  typedef struct { int rmode; int delay; int hs; int vec; int rd; int wr; int max_o; int coinc; } scen_t;

  int total = 0, bad = 0;
  int ev[NCMD], et[NCMD], eb[NCMD], ec[NCMD], lg[NCMD];
  int ph = 0, idx = 0, issued = 0, outst = 0, cyc = 0, last_due = 0;
  int dq[$];
  int ready_mode = 0, done_delay = 1;
  bit mon_on = 1'b0;
  int hs_cnt = 0, vec_cnt = 0, rd_cnt = 0, wr_cnt = 0, max_out = 0, coinc = 0;
  int prev_f = 0;
  bit prev_pending = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pack(input int v, input int t, input int b, input int c);
    return (v << 8) | (t << 5) | (b << 2) | c;
  endfunction

  function automatic int dut_cmd();
    return pack(int'(cmd_vec), int'(cmd_row_top), int'(cmd_row_bot), int'(cmd_col));
  endfunction

  function automatic int all_outs();
    return int'({rd_A, rd_A_row_addr, rd_A_col_addr, cmd_valid, cmd_vec, cmd_row_top,
                 cmd_row_bot, cmd_col, wr_R, wr_R_row_addr, wr_R_col_addr, valid});
  endfunction

  task automatic clear_stats();
    hs_cnt = 0; vec_cnt = 0; rd_cnt = 0; wr_cnt = 0; max_out = 0; coinc = 0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 3000) begin @(negedge clk); n++; end
    chk(name, int'(valid), 1);
  endtask

  task automatic wait_issued(input int target, input string name);
    int n = 0;
    while (issued < target && n < 3000) begin @(negedge clk); n++; end
    chk(name, int'(issued >= target), 1);
  endtask

  // PE side: completions in order, one per cycle at most.
  initial begin : driver
    forever begin
      @(posedge clk); #1;
      cyc++;
      cmd_done = 1'b0;
      if (dq.size() > 0 && dq[0] <= cyc) begin
        void'(dq.pop_front());
        cmd_done = 1'b1;
      end
      case (ready_mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = ($urandom_range(0, 3) != 0);
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  // Reference model: per-cycle expectations from phase, element index, issue count and credit.
  initial begin : monitor
    bit allowed, mhs, credit;
    int f, due;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        f = dut_cmd();
        chk("rd_A", int'(rd_A), int'(ph == PH_LOAD));
        if (ph == PH_LOAD) chk("rd_addr", int'({rd_A_row_addr, rd_A_col_addr}), idx);
        chk("wr_R", int'(wr_R), int'(ph == PH_WRITE));
        if (ph == PH_WRITE) chk("wr_addr", int'({wr_R_row_addr, wr_R_col_addr}), idx);
        chk("valid", int'(valid), int'(ph == PH_DONE));
        allowed = 1'b0;
        if (ph == PH_ISSUE && issued < NCMD)
          allowed = (ev[issued] != 0) ? (outst == 0) : (outst < MAX_OUT);
        chk("cmd_valid", int'(cmd_valid), int'(allowed));
        if (cmd_valid && issued < NCMD)
          chk("cmd_fields", f, pack(ev[issued], et[issued], eb[issued], ec[issued]));
        if (prev_pending) chk("cmd_stable", (int'(cmd_valid) << 9) | f, (1 << 9) | prev_f);
        if (rd_A) rd_cnt++;
        if (wr_R) wr_cnt++;
        if (outst > max_out) max_out = outst;
        if (ph == PH_ISSUE && outst == MAX_OUT && cmd_done) coinc++;
        prev_pending = cmd_valid && !cmd_ready && !rst;
        prev_f = f;
        if (cmd_valid && cmd_ready && !rst) begin
          due = cyc + ((done_delay > 0) ? done_delay : int'($urandom_range(1, 8)));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          dq.push_back(due);
        end
        if (rst) begin
          ph = PH_IDLE; idx = 0; issued = 0; outst = 0;
        end else begin
          mhs = allowed && cmd_ready;
          credit = cmd_done && (outst > 0);
          if (mhs) begin
            lg[issued] = f;
            hs_cnt++;
            if (ev[issued] != 0) vec_cnt++;
          end
          case (ph)
            PH_IDLE:  if (en) begin ph = PH_LOAD; idx = 0; issued = 0; end
            PH_LOAD:  begin idx++; if (idx == NELEM) ph = PH_ISSUE; end
            PH_ISSUE: if (mhs && issued == NCMD - 1) ph = PH_DRAIN;
            PH_DRAIN: if (outst == 0) begin ph = PH_WRITE; idx = 0; end
            PH_WRITE: begin idx++; if (idx == NELEM) ph = PH_DONE; end
            PH_DONE:  if (!en) ph = PH_IDLE;
            default:  ph = PH_IDLE;
          endcase
          if (mhs) issued++;
          outst = outst + int'(mhs) - int'(credit);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    ref_t  rt[6];
    scen_t sc[4];
    int n, f0, i0;

    n = 0;
    for (int j = 0; j < 4; j++)
      for (int i = 7; i > j; i--) begin
        ev[n] = 1; et[n] = i - 1; eb[n] = i; ec[n] = j; n++;
        for (int k = j + 1; k < 4; k++) begin
          ev[n] = 0; et[n] = i - 1; eb[n] = i; ec[n] = k; n++;
        end
      end

    rt[0] = '{0, 1, 6, 7, 0};
    rt[1] = '{1, 0, 6, 7, 1};
    rt[2] = '{2, 0, 6, 7, 2};
    rt[3] = '{3, 0, 6, 7, 3};
    rt[4] = '{4, 1, 5, 6, 0};
    rt[5] = '{59, 1, 3, 4, 3};

    sc[0] = '{0, 1, 60, 22, 32, 32, 1, 0};
    sc[1] = '{1, 1, 60, 22, 32, 32, 1, 0};
    sc[2] = '{0, 6, 60, 22, 32, 32, 2, 1};
    sc[3] = '{1, 0, 60, 22, 32, 32, -1, 0};

    @(posedge clk); #1;
    chk("reset_outs", all_outs(), 0);
    mon_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #2;
      clear_stats();
      ready_mode = sc[s].rmode;
      done_delay = sc[s].delay;
      en = 1'b1;
      wait_valid("run_valid");
      chk("run_hs", hs_cnt, sc[s].hs);
      chk("run_vec", vec_cnt, sc[s].vec);
      chk("run_rd", rd_cnt, sc[s].rd);
      chk("run_wr", wr_cnt, sc[s].wr);
      if (sc[s].max_o >= 0) chk("run_max_out", max_out, sc[s].max_o);
      if (sc[s].coinc != 0) chk("run_coinc_seen", int'(coinc > 0), 1);
      if (s == 0)
        for (int r = 0; r < 6; r++)
          chk("cmd_order", lg[rt[r].n], pack(rt[r].v, rt[r].t, rt[r].b, rt[r].c));
      @(posedge clk); #2 en = 1'b0;
      repeat (3) @(posedge clk);
    end

    // Back-pressure: ready held low for five cycles with a command on offer.
    @(posedge clk); #2;
    clear_stats();
    ready_mode = 0; done_delay = 1; en = 1'b1;
    wait_issued(10, "stall_reach");
    ready_mode = 2;
    n = 0;
    while (!(cmd_valid && !cmd_ready) && n < 50) begin @(negedge clk); n++; end
    chk("stall_seen", int'(cmd_valid && !cmd_ready), 1);
    f0 = (1 << 9) | dut_cmd();
    i0 = issued;
    repeat (4) begin
      @(negedge clk);
      chk("stall_hold", (int'(cmd_valid) << 9) | dut_cmd(), f0);
    end
    ready_mode = 0;
    wait_valid("stall_run_valid");
    chk("stall_hs", hs_cnt, 60);
    chk("stall_vec", vec_cnt, 22);
    chk("stall_accept", lg[i0], f0 & 'h1ff);
    @(posedge clk); #2 en = 1'b0;
    repeat (3) @(posedge clk);

    // Reset in the middle of ISSUE with en still high.
    @(posedge clk); #2;
    clear_stats();
    ready_mode = 0; done_delay = 1; en = 1'b1;
    wait_issued(20, "rst_reach");
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_outs", all_outs(), 0);
    rst = 1'b0;
    clear_stats();
    @(posedge clk); #1;
    chk("restart_load", int'({rd_A, rd_A_row_addr, rd_A_col_addr}), 32);
    wait_valid("rst_run_valid");
    chk("rst_run_hs", hs_cnt, 60);
    chk("rst_run_rd", rd_cnt, 32);
    chk("rst_run_wr", wr_cnt, 32);

    // DONE hold, release and relaunch.
    repeat (10) begin
      @(negedge clk);
      chk("done_hold", int'(valid), 1);
    end
    @(posedge clk); #2 en = 1'b0;
    @(posedge clk); #1;
    chk("done_drop", int'({valid, rd_A, wr_R, cmd_valid}), 0);
    en = 1'b1;
    clear_stats();
    @(posedge clk); #1;
    chk("relaunch_load", int'({rd_A, rd_A_row_addr, rd_A_col_addr}), 32);
    wait_valid("relaunch_valid");
    chk("relaunch_hs", hs_cnt, 60);
    @(posedge clk); #2 en = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
